// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch unit and a
// load/store unit. One transaction is in flight at a time, moving through
// IDLE -> REQ -> WAIT -> RESP. Simultaneous requests alternate between the two
// requesters. A WAIT that runs TIMEOUT cycles without a completion ends in an
// error response.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_rvalid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    output logic                  ifu_err,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_we,
    input  logic [1:0]            lsu_format,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_rvalid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  lsu_err,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [1:0]            mem_format,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // The WAIT counter must be able to hold the value TIMEOUT itself.
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_IFU,
        OWN_LSU
    } owner_e;

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic [1:0]            format_q, format_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic grant_ifu, grant_lsu;
    logic accept_ifu, accept_lsu;
    logic timeout_hit;

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));

    // Arbitration: a lone requester wins; on a conflict the one not granted last wins.
    always_comb begin
        grant_lsu  = lsu_req_valid && (!ifu_req_valid || (last_grant_q == OWN_IFU));
        grant_ifu  = ifu_req_valid && !grant_lsu;
        accept_ifu = (state_q == ST_IDLE) && grant_ifu;
        accept_lsu = (state_q == ST_IDLE) && grant_lsu;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a completion outside WAIT has no effect on the sequence.
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_ifu || accept_lsu) state_d = ST_REQ;
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (mem_rvalid || timeout_hit) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: readies only in IDLE, memory pulse in REQ, owner response in RESP.
    always_comb begin
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req       = 1'b0;
        ifu_rvalid    = 1'b0;
        ifu_rdata     = '0;
        ifu_err       = 1'b0;
        lsu_rvalid    = 1'b0;
        lsu_rdata     = '0;
        lsu_err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ifu_req_ready = accept_ifu;
                lsu_req_ready = accept_lsu;
            end
            ST_REQ: mem_req = 1'b1;
            ST_RESP: begin
                if (owner_q == OWN_LSU) begin
                    lsu_rvalid = 1'b1;
                    lsu_rdata  = rdata_q;
                    lsu_err    = err_q;
                end else begin
                    ifu_rvalid = 1'b1;
                    ifu_rdata  = rdata_q;
                    ifu_err    = err_q;
                end
            end
            default: ;
        endcase
    end

    // Request fields are driven from the latched copy, never from live requester inputs.
    assign mem_we     = we_q;
    assign mem_format = format_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    // Datapath next-state: latch at handshake, count WAIT cycles, capture the completion.
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        format_d     = format_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cnt_d        = '0;

        if (accept_ifu) begin
            owner_d      = OWN_IFU;
            last_grant_d = OWN_IFU;
            we_d         = 1'b0;
            format_d     = 2'b10;
            addr_d       = ifu_addr;
            wdata_d      = '0;
        end else if (accept_lsu) begin
            owner_d      = OWN_LSU;
            last_grant_d = OWN_LSU;
            we_d         = lsu_we;
            format_d     = lsu_format;
            addr_d       = lsu_addr;
            wdata_d      = lsu_wdata;
        end

        case (state_q)
            // The first WAIT cycle is count 1.
            ST_REQ: cnt_d = CNT_W'(1);
            ST_WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears the capture registers and the counter, and the
    // first conflict after reset goes to the LSU.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            we_q         <= 1'b0;
            format_q     <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            format_q     <= format_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter. A cycle-by-cycle vector
// table covers the plain transaction flow. Hand-written sequences cover
// alternation from reset, timeout, and reset in the middle of a transaction.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rvalid, ifu_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_rvalid, lsu_err;
    logic [1:0]  lsu_format;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_req, mem_we, mem_rvalid;
    logic [1:0]  mem_format;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
        .lsu_format(lsu_format), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_format(mem_format), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // One row per clock cycle: requester and memory inputs, then expected outputs.
    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic        lwe;
        logic [1:0]  lfmt;
        logic [31:0] la;
        logic [31:0] lwd;
        logic        mrv;
        logic [31:0] mrd;
        logic [1:0]  e_rdy;   // {ifu_req_ready, lsu_req_ready}
        logic        e_mreq;
        logic [66:0] e_mem;   // {we, format, addr, wdata}, checked only when e_mreq
        logic [33:0] e_ifu;   // {rvalid, err, rdata}
        logic [33:0] e_lsu;   // {rvalid, err, rdata}
    } vec_t;

    localparam logic [66:0] NOM = '0;
    localparam logic [33:0] Z34 = '0;

    vec_t vecs[19];

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] all_outs();
        return {ifu_req_ready, lsu_req_ready, ifu_rvalid, ifu_err, ifu_rdata,
                lsu_rvalid, lsu_err, lsu_rdata, mem_req, mem_we, mem_format, mem_addr, mem_wdata};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_format = 2'b00; lsu_addr = '0; lsu_wdata = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();

        // Plain flow: IFU fetch, LSU store, then conflicts with alternating grants.
        vecs[0]  = '{1'b1, 32'h80000000, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
                     2'b10, 1'b0, NOM, Z34, Z34};
        vecs[1]  = '{1'b0, 32'h12345678, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h00000BAD,
                     2'b00, 1'b1, {1'b0, 2'b10, 32'h80000000, 32'h0}, Z34, Z34};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'h00000413,
                     2'b00, 1'b0, NOM, Z34, Z34};
        vecs[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
                     2'b00, 1'b0, NOM, {1'b1, 1'b0, 32'h00000413}, Z34};
        vecs[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
                     2'b00, 1'b0, NOM, Z34, Z34};
        vecs[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h80000010, 32'h0000BEEF, 1'b0, 32'h0,
                     2'b01, 1'b0, NOM, Z34, Z34};
        vecs[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b11, 32'hDEADBEEF, 32'h12345678, 1'b0, 32'h0,
                     2'b00, 1'b1, {1'b1, 2'b01, 32'h80000010, 32'h0000BEEF}, Z34, Z34};
        vecs[7]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF,
                     2'b00, 1'b0, NOM, Z34, Z34};
        vecs[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
                     2'b00, 1'b0, NOM, Z34, {1'b1, 1'b0, 32'h0}};
        vecs[9]  = '{1'b1, 32'h00001000, 1'b1, 1'b0, 2'b00, 32'h00002000, 32'h11111111, 1'b0, 32'h0,
                     2'b10, 1'b0, NOM, Z34, Z34};
        vecs[10] = '{1'b1, 32'h00001000, 1'b1, 1'b0, 2'b00, 32'h00002000, 32'h11111111, 1'b0, 32'h0,
                     2'b00, 1'b1, {1'b0, 2'b10, 32'h00001000, 32'h0}, Z34, Z34};
        vecs[11] = '{1'b1, 32'h00001000, 1'b1, 1'b0, 2'b00, 32'h00002000, 32'h11111111, 1'b0, 32'h0,
                     2'b00, 1'b0, NOM, Z34, Z34};
        vecs[12] = '{1'b1, 32'h00001000, 1'b1, 1'b0, 2'b00, 32'h00002000, 32'h11111111, 1'b1, 32'hCAFEF00D,
                     2'b00, 1'b0, NOM, Z34, Z34};
        vecs[13] = '{1'b1, 32'h00001000, 1'b1, 1'b0, 2'b00, 32'h00002000, 32'h11111111, 1'b0, 32'h0,
                     2'b00, 1'b0, NOM, {1'b1, 1'b0, 32'hCAFEF00D}, Z34};
        vecs[14] = '{1'b1, 32'h00001000, 1'b1, 1'b0, 2'b00, 32'h00002000, 32'h11111111, 1'b0, 32'h0,
                     2'b01, 1'b0, NOM, Z34, Z34};
        vecs[15] = '{1'b1, 32'h00001000, 1'b1, 1'b0, 2'b00, 32'h00002000, 32'h11111111, 1'b0, 32'h0,
                     2'b00, 1'b1, {1'b0, 2'b00, 32'h00002000, 32'h11111111}, Z34, Z34};
        vecs[16] = '{1'b1, 32'h00001000, 1'b1, 1'b0, 2'b00, 32'h00002000, 32'h11111111, 1'b1, 32'h000000A5,
                     2'b00, 1'b0, NOM, Z34, Z34};
        vecs[17] = '{1'b1, 32'h00001000, 1'b1, 1'b0, 2'b00, 32'h00002000, 32'h11111111, 1'b0, 32'h0,
                     2'b00, 1'b0, NOM, Z34, {1'b1, 1'b0, 32'h000000A5}};
        vecs[18] = '{1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0,
                     2'b00, 1'b0, NOM, Z34, Z34};

        // Reset state.
        do_reset();
        #1 check("reset_outs", all_outs(), '0);

        // Vector table.
        for (int i = 0; i < 19; i++) begin
            step();
            ifu_req_valid = vecs[i].iv;  ifu_addr = vecs[i].ia;
            lsu_req_valid = vecs[i].lv;  lsu_we = vecs[i].lwe; lsu_format = vecs[i].lfmt;
            lsu_addr = vecs[i].la;       lsu_wdata = vecs[i].lwd;
            mem_rvalid = vecs[i].mrv;    mem_rdata = vecs[i].mrd;
            #1;
            check($sformatf("vec%0d_ready", i), {ifu_req_ready, lsu_req_ready}, vecs[i].e_rdy);
            check($sformatf("vec%0d_mem_req", i), mem_req, vecs[i].e_mreq);
            if (vecs[i].e_mreq)
                check($sformatf("vec%0d_mem_fields", i), {mem_we, mem_format, mem_addr, mem_wdata}, vecs[i].e_mem);
            check($sformatf("vec%0d_ifu_resp", i), {ifu_rvalid, ifu_err, ifu_rdata}, vecs[i].e_ifu);
            check($sformatf("vec%0d_lsu_resp", i), {lsu_rvalid, lsu_err, lsu_rdata}, vecs[i].e_lsu);
        end

        // Both held valid from reset: LSU first, then alternation.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            logic to_lsu;
            to_lsu = (k % 2 == 0);
            step();
            ifu_req_valid = 1'b1; ifu_addr = 32'h000000A0;
            lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_format = 2'b10; lsu_addr = 32'h000000B0;
            mem_rvalid = 1'b0;
            #1 check($sformatf("alt%0d_grant", k), {ifu_req_ready, lsu_req_ready}, to_lsu ? 2'b01 : 2'b10);
            step();
            #1 check($sformatf("alt%0d_mem", k), {mem_req, mem_addr}, {1'b1, to_lsu ? 32'h000000B0 : 32'h000000A0});
            step();
            mem_rvalid = 1'b1; mem_rdata = 32'h100 + k;
            step();
            mem_rvalid = 1'b0;
            #1 check($sformatf("alt%0d_resp", k), {ifu_rvalid, lsu_rvalid, ifu_rdata | lsu_rdata},
                     {~to_lsu, to_lsu, 32'h100 + k});
        end

        // Timeout: no completion for 4 WAIT cycles, then a stray completion is ignored.
        do_reset();
        step();
        ifu_req_valid = 1'b1; ifu_addr = 32'h00000040;
        #1 check("to_grant", {ifu_req_ready, lsu_req_ready}, 2'b10);
        step();
        ifu_req_valid = 1'b0;
        #1 check("to_mem", {mem_req, mem_addr}, {1'b1, 32'h00000040});
        for (int w = 1; w <= 4; w++) begin
            step();
            #1 check($sformatf("to_wait%0d", w), ifu_rvalid, 1'b0);
        end
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h00000055;
        #1 check("to_err_resp", {ifu_rvalid, ifu_err, ifu_rdata}, {1'b1, 1'b1, 32'h0});
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h00000066;
        lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_format = 2'b10; lsu_addr = 32'h00000080;
        #1 check("to_stray_idle", {lsu_req_ready, ifu_rvalid, lsu_rvalid}, 3'b100);
        step();
        mem_rvalid = 1'b0; lsu_req_valid = 1'b0;
        #1 check("to_lsu_mem", {mem_req, mem_addr}, {1'b1, 32'h00000080});
        for (int w = 1; w <= 3; w++) begin
            step();
            #1 check($sformatf("to_lsu_wait%0d", w), lsu_rvalid, 1'b0);
        end
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h00000077;
        step();
        mem_rvalid = 1'b0;
        #1 check("to_last_cycle_ok", {lsu_rvalid, lsu_err, lsu_rdata}, {1'b1, 1'b0, 32'h00000077});

        // Reset during WAIT aborts the LSU transaction and restores last_grant.
        do_reset();
        step();
        lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_format = 2'b10; lsu_addr = 32'h00000C00;
        lsu_wdata = 32'h0000ABCD;
        #1 check("ab_grant", lsu_req_ready, 1'b1);
        step();
        lsu_req_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1 check("ab_outs_zero", all_outs(), '0);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h00000099;
        #1 check("ab_no_resp1", all_outs(), '0);
        step();
        mem_rvalid = 1'b0;
        #1 check("ab_no_resp2", all_outs(), '0);
        step();
        ifu_req_valid = 1'b1; ifu_addr = 32'h00000D00;
        lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h00000E00;
        #1 check("ab_first_conflict", {ifu_req_ready, lsu_req_ready}, 2'b01);
        step();
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
